// File: rtl/ex_mem_if.sv
// Data-RAM request bus between the ex_mem stage (master) and the data RAM (slave).
interface ex_mem_if #(
    parameter int BUS_WIDTH  = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  mem_req;
    logic                  mem_we;
    logic [BUS_WIDTH-1:0]  mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [3:0]            mem_wstrb;
    logic                  mem_addr_ok;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_addr_ok
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_addr_ok
    );
endinterface

// File: rtl/ex_mem.sv
// EX/MEM pipeline stage: latches execute results, issues the data-RAM
// load/store request over a req/addr_ok handshake, formats store strobes and
// data, and hands rd/control/func3/full address on to mem_wb.
module ex_mem #(
    parameter int BUS_WIDTH  = 32,
    parameter int DATA_WIDTH = 32,
    parameter int RD_WIDTH   = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  hold,
    input  logic                  flush,
    input  logic                  valid_ex,
    input  logic                  ready_go_ex,
    output logic                  allow_in_mem,
    input  logic                  allow_in_wb,
    output logic                  valid_mem,
    output logic                  ready_go_mem,
    input  logic [BUS_WIDTH-1:0]  alu_result_i,
    input  logic [DATA_WIDTH-1:0] rs2_data_i,
    input  logic [RD_WIDTH-1:0]   rd_ex,
    input  logic [1:0]            control_flow_i,
    input  logic                  mem_write_i,
    input  logic [2:0]            ins_func3_i,
    output logic [BUS_WIDTH-1:0]  mem_address_o,
    output logic [RD_WIDTH-1:0]   rd_mem,
    output logic [1:0]            control_flow_o,
    output logic [2:0]            ins_func3_o,
    ex_mem_if.master              ram
);

    typedef enum logic [2:0] {
        S_IDLE = 3'b001,
        S_REQ  = 3'b010,
        S_WAIT = 3'b100
    } state_e;

    state_e                state_q, state_d;
    logic                  valid_q;
    logic [BUS_WIDTH-1:0]  addr_q;
    logic [DATA_WIDTH-1:0] rs2_q;
    logic [RD_WIDTH-1:0]   rd_q;
    logic [1:0]            control_flow_q;
    logic                  mem_write_q;
    logic [2:0]            func3_q;

    logic mem_op;
    logic in_req;
    logic in_wait;
    logic leave_ok;
    logic load_en;
    logic incoming;

    // Handshake and acceptance terms shared by the valid register and FSM.
    assign mem_op       = control_flow_q[1] | mem_write_q;
    assign in_req       = (state_q == S_REQ);
    assign in_wait      = (state_q == S_WAIT);
    assign leave_ok     = allow_in_wb & ~hold;
    assign ready_go_mem = ~mem_op | (in_req & ram.mem_addr_ok) | in_wait;
    assign allow_in_mem = ~valid_q | (ready_go_mem & leave_ok);
    assign load_en      = allow_in_mem & valid_ex & ready_go_ex & ~flush;
    assign incoming     = load_en & (control_flow_i[1] | mem_write_i);
    assign valid_mem    = valid_q;

    // Valid bit: flush always kills; otherwise refill whenever the slot opens.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (allow_in_mem) begin
            valid_q <= valid_ex & ready_go_ex;
        end
    end

    // Datapath capture of the instruction entering this stage.
    // NOTE: datapath registers carry no reset; their contents are ignored while valid_mem is low.
    always_ff @(posedge clk) begin
        if (load_en) begin
            addr_q         <= alu_result_i;
            rs2_q          <= rs2_data_i;
            rd_q           <= rd_ex;
            control_flow_q <= control_flow_i;
            mem_write_q    <= mem_write_i;
            func3_q        <= ins_func3_i;
        end
    end

    // Request FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request FSM next state: one request per instruction, back-to-back ops re-enter S_REQ.
    // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (incoming) state_d = S_REQ;
            end
            S_REQ: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (ram.mem_addr_ok) begin
                    if (leave_ok) state_d = incoming ? S_REQ : S_IDLE;
                    else          state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (leave_ok) begin
                    state_d = incoming ? S_REQ : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Store formatting: byte strobes and lane-replicated write data from func3 and addr[1:0].
    always_comb begin
        ram.mem_wstrb = 4'b0000;
        ram.mem_wdata = rs2_q;
        case (func3_q)
            3'b000: begin
                ram.mem_wdata = {(DATA_WIDTH/8){rs2_q[7:0]}};
                if (mem_write_q) ram.mem_wstrb = 4'b0001 << addr_q[1:0];
            end
            3'b001: begin
                ram.mem_wdata = {(DATA_WIDTH/16){rs2_q[15:0]}};
                if (mem_write_q) ram.mem_wstrb = 4'b0011 << {addr_q[1], 1'b0};
            end
            3'b010: begin
                if (mem_write_q) ram.mem_wstrb = 4'b1111;
            end
            default: ram.mem_wstrb = 4'b0000;
        endcase
    end

    // Request outputs; mem_req drops combinationally on flush or reset.
    assign ram.mem_req  = in_req & valid_q & ~flush;
    assign ram.mem_we   = mem_write_q;
    assign ram.mem_addr = {addr_q[BUS_WIDTH-1:2], 2'b00};

    // Values handed to mem_wb.
    assign mem_address_o  = addr_q;
    assign rd_mem         = rd_q;
    assign control_flow_o = control_flow_q;
    assign ins_func3_o    = func3_q;

endmodule

// File: tb/tb_ex_mem.sv
// Directed self-checking bench for ex_mem: ALU pass-through, stores, loads,
// wait/hold, flush, back-to-back requests and asynchronous reset.
module tb_ex_mem;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hold, flush, valid_ex, ready_go_ex, allow_in_wb;
    logic        allow_in_mem, valid_mem, ready_go_mem;
    logic [31:0] alu_result_i, rs2_data_i, mem_address_o;
    logic [4:0]  rd_ex, rd_mem;
    logic [1:0]  control_flow_i, control_flow_o;
    logic        mem_write_i;
    logic [2:0]  ins_func3_i, ins_func3_o;

    int n_checks = 0;
    int n_errors = 0;

    ex_mem_if #(.BUS_WIDTH(32), .DATA_WIDTH(32)) ram_if ();

    ex_mem #(.BUS_WIDTH(32), .DATA_WIDTH(32), .RD_WIDTH(5)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .hold           (hold),
        .flush          (flush),
        .valid_ex       (valid_ex),
        .ready_go_ex    (ready_go_ex),
        .allow_in_mem   (allow_in_mem),
        .allow_in_wb    (allow_in_wb),
        .valid_mem      (valid_mem),
        .ready_go_mem   (ready_go_mem),
        .alu_result_i   (alu_result_i),
        .rs2_data_i     (rs2_data_i),
        .rd_ex          (rd_ex),
        .control_flow_i (control_flow_i),
        .mem_write_i    (mem_write_i),
        .ins_func3_i    (ins_func3_i),
        .mem_address_o  (mem_address_o),
        .rd_mem         (rd_mem),
        .control_flow_o (control_flow_o),
        .ins_func3_o    (ins_func3_o),
        .ram            (ram_if)
    );

    always #5 clk = ~clk;

    // Inputs change 1 unit after the rising edge; outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_ex(input logic v, input logic [31:0] alu, input logic [31:0] rs2,
                            input logic [4:0] rd, input logic [1:0] cf, input logic mw,
                            input logic [2:0] f3);
        valid_ex       = v;
        ready_go_ex    = v;
        alu_result_i   = alu;
        rs2_data_i     = rs2;
        rd_ex          = rd;
        control_flow_i = cf;
        mem_write_i    = mw;
        ins_func3_i    = f3;
    endtask

    initial begin
        rst_n = 1'b0;
        hold = 1'b0; flush = 1'b0; allow_in_wb = 1'b1;
        ram_if.mem_addr_ok = 1'b0;
        drive_ex(1'b0, 32'h0, 32'h0, 5'd0, 2'b00, 1'b0, 3'b000);

        // Reset state
        settle();
        check("rst_valid", {31'b0, valid_mem}, 32'd0);
        check("rst_req", {31'b0, ram_if.mem_req}, 32'd0);
        check("rst_allow_in", {31'b0, allow_in_mem}, 32'd1);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // 1: ADD rd=5 passes in one cycle, no request
        drive_ex(1'b1, 32'h0000_0010, 32'h0, 5'd5, 2'b01, 1'b0, 3'b000);
        settle();
        check("add_allow_in", {31'b0, allow_in_mem}, 32'd1);
        tick();
        drive_ex(1'b0, 32'h0, 32'h0, 5'd0, 2'b00, 1'b0, 3'b000);
        settle();
        check("add_valid", {31'b0, valid_mem}, 32'd1);
        check("add_ready_go", {31'b0, ready_go_mem}, 32'd1);
        check("add_req", {31'b0, ram_if.mem_req}, 32'd0);
        check("add_rd", {27'b0, rd_mem}, 32'd5);
        check("add_cf", {30'b0, control_flow_o}, 32'd1);
        tick();
        check("add_gone", {31'b0, valid_mem}, 32'd0);
        check("add_req_after", {31'b0, ram_if.mem_req}, 32'd0);

        // 2: SW 0x104, addr_ok arrives in the third request cycle
        drive_ex(1'b1, 32'h0000_0104, 32'hDEAD_BEEF, 5'd0, 2'b00, 1'b1, 3'b010);
        tick();
        drive_ex(1'b0, 32'h0, 32'h0, 5'd0, 2'b00, 1'b0, 3'b000);
        settle();
        check("sw_req_c1", {31'b0, ram_if.mem_req}, 32'd1);
        check("sw_we", {31'b0, ram_if.mem_we}, 32'd1);
        check("sw_wstrb", {28'b0, ram_if.mem_wstrb}, 32'hF);
        check("sw_addr_c1", ram_if.mem_addr, 32'h0000_0104);
        check("sw_wdata", ram_if.mem_wdata, 32'hDEAD_BEEF);
        check("sw_ready_go_c1", {31'b0, ready_go_mem}, 32'd0);
        check("sw_allow_in_c1", {31'b0, allow_in_mem}, 32'd0);
        tick();
        check("sw_req_c2", {31'b0, ram_if.mem_req}, 32'd1);
        check("sw_addr_c2", ram_if.mem_addr, 32'h0000_0104);
        check("sw_ready_go_c2", {31'b0, ready_go_mem}, 32'd0);
        tick();
        ram_if.mem_addr_ok = 1'b1;
        settle();
        check("sw_req_c3", {31'b0, ram_if.mem_req}, 32'd1);
        check("sw_addr_c3", ram_if.mem_addr, 32'h0000_0104);
        check("sw_ready_go_c3", {31'b0, ready_go_mem}, 32'd1);
        check("sw_allow_in_c3", {31'b0, allow_in_mem}, 32'd1);
        tick();
        ram_if.mem_addr_ok = 1'b0;
        settle();
        check("sw_gone", {31'b0, valid_mem}, 32'd0);
        check("sw_req_after", {31'b0, ram_if.mem_req}, 32'd0);

        // 3: SB 0x103 then SH 0x102 back to back
        drive_ex(1'b1, 32'h0000_0103, 32'h0000_00A5, 5'd0, 2'b00, 1'b1, 3'b000);
        tick();
        drive_ex(1'b1, 32'h0000_0102, 32'h0000_1234, 5'd0, 2'b00, 1'b1, 3'b001);
        ram_if.mem_addr_ok = 1'b1;
        settle();
        check("sb_req", {31'b0, ram_if.mem_req}, 32'd1);
        check("sb_wstrb", {28'b0, ram_if.mem_wstrb}, 32'h8);
        check("sb_wdata", ram_if.mem_wdata, 32'hA5A5_A5A5);
        check("sb_addr", ram_if.mem_addr, 32'h0000_0100);
        check("sb_allow_in", {31'b0, allow_in_mem}, 32'd1);
        tick();
        drive_ex(1'b0, 32'h0, 32'h0, 5'd0, 2'b00, 1'b0, 3'b000);
        settle();
        check("sh_req", {31'b0, ram_if.mem_req}, 32'd1);
        check("sh_wstrb", {28'b0, ram_if.mem_wstrb}, 32'hC);
        check("sh_wdata", ram_if.mem_wdata, 32'h1234_1234);
        check("sh_addr", ram_if.mem_addr, 32'h0000_0100);
        check("sh_full_addr", mem_address_o, 32'h0000_0102);
        tick();
        ram_if.mem_addr_ok = 1'b0;
        settle();
        check("sh_gone", {31'b0, valid_mem}, 32'd0);
        check("sh_req_after", {31'b0, ram_if.mem_req}, 32'd0);

        // 4: LW 0x200, immediate addr_ok, downstream blocked for two cycles
        allow_in_wb = 1'b0;
        ram_if.mem_addr_ok = 1'b1;
        drive_ex(1'b1, 32'h0000_0200, 32'h0, 5'd7, 2'b11, 1'b0, 3'b010);
        tick();
        drive_ex(1'b0, 32'h0, 32'h0, 5'd0, 2'b00, 1'b0, 3'b000);
        settle();
        check("lw_req", {31'b0, ram_if.mem_req}, 32'd1);
        check("lw_we", {31'b0, ram_if.mem_we}, 32'd0);
        check("lw_wstrb", {28'b0, ram_if.mem_wstrb}, 32'h0);
        check("lw_addr", ram_if.mem_addr, 32'h0000_0200);
        check("lw_ready_go", {31'b0, ready_go_mem}, 32'd1);
        check("lw_allow_in_blk", {31'b0, allow_in_mem}, 32'd0);
        tick();
        check("lw_wait_req", {31'b0, ram_if.mem_req}, 32'd0);
        check("lw_wait_valid", {31'b0, valid_mem}, 32'd1);
        check("lw_wait_ready_go", {31'b0, ready_go_mem}, 32'd1);
        check("lw_wait_allow_in", {31'b0, allow_in_mem}, 32'd0);
        tick();
        allow_in_wb = 1'b1;
        settle();
        check("lw_wait2_req", {31'b0, ram_if.mem_req}, 32'd0);
        check("lw_wait2_allow_in", {31'b0, allow_in_mem}, 32'd1);
        check("lw_wait2_rd", {27'b0, rd_mem}, 32'd7);
        tick();
        ram_if.mem_addr_ok = 1'b0;
        settle();
        check("lw_gone", {31'b0, valid_mem}, 32'd0);
        check("lw_req_after", {31'b0, ram_if.mem_req}, 32'd0);

        // 5: LW with no addr_ok, flushed while requesting
        drive_ex(1'b1, 32'h0000_0300, 32'h0, 5'd3, 2'b11, 1'b0, 3'b010);
        tick();
        drive_ex(1'b0, 32'h0, 32'h0, 5'd0, 2'b00, 1'b0, 3'b000);
        settle();
        check("fl_req_c1", {31'b0, ram_if.mem_req}, 32'd1);
        tick();
        flush = 1'b1;
        settle();
        check("fl_req_drop", {31'b0, ram_if.mem_req}, 32'd0);
        tick();
        flush = 1'b0;
        settle();
        check("fl_valid", {31'b0, valid_mem}, 32'd0);
        check("fl_req_after", {31'b0, ram_if.mem_req}, 32'd0);
        tick();
        check("fl_req_later", {31'b0, ram_if.mem_req}, 32'd0);

        // 6: two back-to-back loads, addr_ok always high
        ram_if.mem_addr_ok = 1'b1;
        drive_ex(1'b1, 32'h0000_0010, 32'h0, 5'd8, 2'b11, 1'b0, 3'b010);
        tick();
        drive_ex(1'b1, 32'h0000_0014, 32'h0, 5'd9, 2'b11, 1'b0, 3'b100);
        settle();
        check("b2b_req1", {31'b0, ram_if.mem_req}, 32'd1);
        check("b2b_addr1", ram_if.mem_addr, 32'h0000_0010);
        check("b2b_rd1", {27'b0, rd_mem}, 32'd8);
        check("b2b_f3_1", {29'b0, ins_func3_o}, 32'd2);
        check("b2b_allow_in", {31'b0, allow_in_mem}, 32'd1);
        tick();
        drive_ex(1'b0, 32'h0, 32'h0, 5'd0, 2'b00, 1'b0, 3'b000);
        settle();
        check("b2b_req2", {31'b0, ram_if.mem_req}, 32'd1);
        check("b2b_addr2", ram_if.mem_addr, 32'h0000_0014);
        check("b2b_rd2", {27'b0, rd_mem}, 32'd9);
        check("b2b_f3_2", {29'b0, ins_func3_o}, 32'd4);
        tick();
        check("b2b_req_after", {31'b0, ram_if.mem_req}, 32'd0);
        check("b2b_gone", {31'b0, valid_mem}, 32'd0);

        // 7: hold during request does not suppress it; addr_ok moves to wait
        hold = 1'b1;
        drive_ex(1'b1, 32'h0000_0400, 32'h5555_AAAA, 5'd0, 2'b00, 1'b1, 3'b010);
        settle();
        check("hold_allow_in_empty", {31'b0, allow_in_mem}, 32'd1);
        tick();
        drive_ex(1'b0, 32'h0, 32'h0, 5'd0, 2'b00, 1'b0, 3'b000);
        settle();
        check("hold_req", {31'b0, ram_if.mem_req}, 32'd1);
        check("hold_allow_in", {31'b0, allow_in_mem}, 32'd0);
        tick();
        ram_if.mem_addr_ok = 1'b0;
        settle();
        check("hold_wait_req", {31'b0, ram_if.mem_req}, 32'd0);
        check("hold_wait_valid", {31'b0, valid_mem}, 32'd1);
        hold = 1'b0;
        settle();
        check("hold_release_allow", {31'b0, allow_in_mem}, 32'd1);
        tick();
        check("hold_gone", {31'b0, valid_mem}, 32'd0);

        // 8: flush together with addr_ok
        drive_ex(1'b1, 32'h0000_0500, 32'h0, 5'd4, 2'b11, 1'b0, 3'b010);
        tick();
        drive_ex(1'b0, 32'h0, 32'h0, 5'd0, 2'b00, 1'b0, 3'b000);
        ram_if.mem_addr_ok = 1'b1;
        flush = 1'b1;
        settle();
        check("flok_req", {31'b0, ram_if.mem_req}, 32'd0);
        tick();
        flush = 1'b0;
        settle();
        check("flok_valid", {31'b0, valid_mem}, 32'd0);
        check("flok_req_after", {31'b0, ram_if.mem_req}, 32'd0);
        ram_if.mem_addr_ok = 1'b0;

        // 9: asynchronous reset while a request is pending; func3=011 store has no strobes
        drive_ex(1'b1, 32'h0000_0600, 32'h1111_2222, 5'd0, 2'b00, 1'b1, 3'b011);
        tick();
        drive_ex(1'b0, 32'h0, 32'h0, 5'd0, 2'b00, 1'b0, 3'b000);
        settle();
        check("rsv_req", {31'b0, ram_if.mem_req}, 32'd1);
        check("rsv_wstrb", {28'b0, ram_if.mem_wstrb}, 32'h0);
        rst_n = 1'b0;
        settle();
        check("arst_req", {31'b0, ram_if.mem_req}, 32'd0);
        check("arst_valid", {31'b0, valid_mem}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("arst_req_after", {31'b0, ram_if.mem_req}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
